systolic2x2_sequencer: RTL and testbench
========================================

# systolic2x2_sequencer

Job-level controller for the 2x2 systolic array. It accepts one pair of 2x2 operand matrices over a valid/ready handshake, issues the operands to the array in the array's skewed three-wavefront order with correct `in_valid` framing, waits for the array's `out_valid`, and returns the captured 2x2 result over a second valid/ready handshake. It sits between the job source (DMA/CPU shim) and the array instance. It replaces hand-sequenced stimulus.

## Interface
- `DATA_WIDTH`, 4: operand element width.
- `ACC_WIDTH`, 9: result element width. Must match the array.
- `TIMEOUT`, 15: maximum WAIT cycles before abort. Minimum 1.
- `clk  in  1`: clock, rising edge.
- `rstn  in  1`: reset, asynchronous, active-low.
- `job_valid  in  1`: job offered.
- `job_ready  out  1`: sequencer accepts a job.
- `job_a  in  4*DATA_WIDTH`: packed {a11,a10,a01,a00}.
- `job_b  in  4*DATA_WIDTH`: packed {b11,b10,b01,b00}.
- `arr_in_valid  out  1`: drives array `in_valid`.
- `arr_a00..arr_a11`, `arr_b00..arr_b11  out  DATA_WIDTH each`: drive array operand ports.
- `arr_out_valid  in  1`: array `out_valid`.
- `arr_c00..arr_c11  in  ACC_WIDTH each`: array results.
- `res_valid  out  1`: result available.
- `res_ready  in  1`: consumer takes the result.
- `res_c  out  4*ACC_WIDTH`: packed {c11,c10,c01,c00}.
- `res_err  out  1`: result aborted by timeout. Qualified by `res_valid`.
- `busy  out  1`: state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `job_ready`=1. When `job_valid`&`job_ready`, register `job_a`/`job_b`, clear issue counter `t`, and go to ISSUE.
- ISSUE: `t` runs 0..4, one step per cycle. Only the elements listed below are nonzero; all other `arr_a*`/`arr_b*` drive 0.
  - t=0: `b01`.
  - t=1: `b00`, `b10`.
  - t=2: `b11`, `a00`.
  - t=3: `a01`, `a10`.
  - t=4: `a11`.
  - At t=4, go to WAIT.
- `arr_in_valid`=1 from t=2 through the cycle in which WAIT exits. It is 0 otherwise.
- WAIT: all operand outputs 0. On the first cycle with `arr_out_valid`=1, register `arr_c*` into `res_c`, set `res_err`=0, and go to DONE.
- DONE: `res_valid`=1. `res_c`/`res_err` are held stable until `res_ready`=1, which returns to IDLE. `res_valid` is never withdrawn without `res_ready`.
- A new job is accepted only in IDLE. There is no job overlap and no queueing.
- `arr_out_valid` seen in IDLE, ISSUE or DONE is ignored.
- Results are passed through unmodified. There is no saturation or width change.

## Timing
- Reset (async assert, sync release), all outputs go to 0:
  - `job_ready`=0 while `rstn`=0, then 1 in IDLE after release.
  - `arr_*`=0, `res_valid`=0, `res_c`=0, `res_err`=0, `busy`=0.
  - State is IDLE and the counters are 0.
- Reset asserted mid-job: the job is discarded with no result, and array drive goes to 0 immediately.
- Job handshake edge = cycle J. The t=0 operands appear on the array ports in cycle J+1, and t=4 in cycle J+5.
- WAIT is entered at J+6. With array response latency L cycles after the t=4 cycle, `res_valid` rises one cycle after `arr_out_valid` is sampled.
- `res_ready` held high in DONE: IDLE is re-entered the next cycle and `job_ready`=1 then. Minimum job-to-job spacing is 8 cycles plus array wait.
- `job_valid` and the `res_ready` of the previous job arriving in the same cycle: the job is not accepted until IDLE is reached.

## Configuration
- Macro `SYSTOLIC_SEQ_TIMEOUT_EN`.
- Defined:
  - A WAIT-cycle counter runs. If it reaches `TIMEOUT` with no `arr_out_valid`, go to DONE with `res_err`=1 and `res_c`=0.
  - `arr_out_valid` arriving on the same cycle the count hits `TIMEOUT` wins: normal capture, `res_err`=0.
- Undefined:
  - No counter. WAIT lasts indefinitely and `res_err` is tied 0.

## Test plan
- Reset then a single job, A={a00=4,a01=3,a10=12,a11=4}, B={b00=4,b01=2,b10=6,b11=8}, with an array stub asserting `arr_out_valid` 4 cycles after t=4 and c={1,2,3,4} -> required response:
  - Port sequence: b01=2; then b00=4,b10=6; then b11=8,a00=4; then a01=3,a10=12; then a11=4.
  - `res_c`={4,3,2,1} packed and `res_err`=0.
- Result backpressure: hold `res_ready`=0 for 6 cycles -> `res_valid` and `res_c` stable all 6 cycles, `job_ready`=0 throughout.
- Back-to-back jobs with `job_valid` held high -> second job's t=0 appears exactly 2 cycles after the first job's DONE handshake, and no operand bleed between jobs.
- Reset asserted during ISSUE t=3 -> all `arr_*` are 0 that cycle, no `res_valid`, and a following job runs normally.
- `SYSTOLIC_SEQ_TIMEOUT_EN` defined, stub never responds -> `res_valid`=1 with `res_err`=1 and `res_c`=0 after `TIMEOUT`=15 WAIT cycles.
- `SYSTOLIC_SEQ_TIMEOUT_EN` defined, stub responds on exactly the 15th WAIT cycle -> normal result with `res_err`=0.

Source files
------------

// File: rtl/systolic2x2_sequencer_if.sv
// Job, array-drive and result channels of the 2x2 systolic sequencer.
// master = sequencer side, slave = job source / array / result consumer side.
interface systolic2x2_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 9
);
  logic                    job_valid;
  logic                    job_ready;
  logic [4*DATA_WIDTH-1:0] job_a;
  logic [4*DATA_WIDTH-1:0] job_b;

  logic                    arr_in_valid;
  logic [DATA_WIDTH-1:0]   arr_a00, arr_a01, arr_a10, arr_a11;
  logic [DATA_WIDTH-1:0]   arr_b00, arr_b01, arr_b10, arr_b11;
  logic                    arr_out_valid;
  logic [ACC_WIDTH-1:0]    arr_c00, arr_c01, arr_c10, arr_c11;

  logic                    res_valid;
  logic                    res_ready;
  logic [4*ACC_WIDTH-1:0]  res_c;
  logic                    res_err;
  logic                    busy;

  modport master (
    input  job_valid, job_a, job_b, arr_out_valid,
    input  arr_c00, arr_c01, arr_c10, arr_c11, res_ready,
    output job_ready, arr_in_valid,
    output arr_a00, arr_a01, arr_a10, arr_a11,
    output arr_b00, arr_b01, arr_b10, arr_b11,
    output res_valid, res_c, res_err, busy
  );

  modport slave (
    output job_valid, job_a, job_b, arr_out_valid,
    output arr_c00, arr_c01, arr_c10, arr_c11, res_ready,
    input  job_ready, arr_in_valid,
    input  arr_a00, arr_a01, arr_a10, arr_a11,
    input  arr_b00, arr_b01, arr_b10, arr_b11,
    input  res_valid, res_c, res_err, busy
  );
endinterface

// File: rtl/systolic2x2_sequencer.sv
// Job-level controller for the 2x2 systolic array: skewed operand issue, result capture.
// Optional WAIT timeout enabled by defining SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic2x2_sequencer #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 9,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rstn,
  systolic2x2_sequencer_if.master         bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        t_q, t_d;
  logic [4*DW-1:0]   a_q, a_d, b_q, b_d;
  logic [4*AW-1:0]   c_q, c_d;

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WW-1:0]     w_q, w_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    w_d     = w_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.job_valid) begin
          a_d     = bus.job_a;
          b_d     = bus.job_b;
          t_d     = 3'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (t_q == 3'd4) begin
          t_d     = 3'd0;
          state_d = StWait;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
          w_d     = '0;
`endif
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      StWait: begin
        // A response on the last allowed cycle beats the timeout.
        if (bus.arr_out_valid) begin
          c_d     = {bus.arr_c11, bus.arr_c10, bus.arr_c01, bus.arr_c00};
          state_d = StDone;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (w_q == WW'(TIMEOUT - 1)) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          w_d = w_q + 1'b1;
`endif
        end
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      w_q     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      w_q     <= w_d;
      err_q   <= err_d;
`endif
    end
  end

  // Handshake outputs decode from state so reset clears them without waiting for a clock.
  assign bus.job_ready = rstn & (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.res_valid = (state_q == StDone);
  assign bus.res_c     = c_q;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  assign bus.res_err   = err_q;
`else
  assign bus.res_err   = 1'b0;
`endif

  assign bus.arr_in_valid = ((state_q == StIssue) && (t_q >= 3'd2)) || (state_q == StWait);

  // Three-wavefront skew: B leads A by two steps.
  always_comb begin
    bus.arr_a00 = '0;
    bus.arr_a01 = '0;
    bus.arr_a10 = '0;
    bus.arr_a11 = '0;
    bus.arr_b00 = '0;
    bus.arr_b01 = '0;
    bus.arr_b10 = '0;
    bus.arr_b11 = '0;
    if (state_q == StIssue) begin
      case (t_q)
        3'd0: bus.arr_b01 = b_q[2*DW-1:DW];
        3'd1: begin
          bus.arr_b00 = b_q[DW-1:0];
          bus.arr_b10 = b_q[3*DW-1:2*DW];
        end
        3'd2: begin
          bus.arr_b11 = b_q[4*DW-1:3*DW];
          bus.arr_a00 = a_q[DW-1:0];
        end
        3'd3: begin
          bus.arr_a01 = a_q[2*DW-1:DW];
          bus.arr_a10 = a_q[3*DW-1:2*DW];
        end
        3'd4: bus.arr_a11 = a_q[4*DW-1:3*DW];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic2x2_sequencer.sv
// Directed self-checking bench for systolic2x2_sequencer with a fixed-latency array stub.
module tb_systolic2x2_sequencer;
  logic clk;
  logic rstn;
  int   n_run;
  int   n_fail;

  systolic2x2_sequencer_if #(.DATA_WIDTH(4), .ACC_WIDTH(9)) bus ();

  systolic2x2_sequencer #(.DATA_WIDTH(4), .ACC_WIDTH(9), .TIMEOUT(15)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stub: out_valid stub_lat cycles after the t=4 cycle (J+5).
  int         stub_lat;
  int         stub_cyc;
  logic       stub_armed;
  logic [8:0] stub_c00, stub_c01, stub_c10, stub_c11;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stub_armed <= 1'b0;
      stub_cyc   <= 0;
    end else if (bus.job_valid && bus.job_ready) begin
      stub_armed <= 1'b1;
      stub_cyc   <= 1;
    end else if (stub_armed) begin
      stub_cyc <= stub_cyc + 1;
    end
  end

  assign bus.arr_out_valid = stub_armed && (stub_cyc == 5 + stub_lat);
  assign bus.arr_c00 = stub_c00;
  assign bus.arr_c01 = stub_c01;
  assign bus.arr_c10 = stub_c10;
  assign bus.arr_c11 = stub_c11;

  logic [31:0] obs_ops;
  assign obs_ops = {bus.arr_a00, bus.arr_a01, bus.arr_a10, bus.arr_a11,
                    bus.arr_b00, bus.arr_b01, bus.arr_b10, bus.arr_b11};

  function automatic logic [31:0] exp_ops(input logic [15:0] a, input logic [15:0] b,
                                          input int t);
    logic [3:0] a00, a01, a10, a11, b00, b01, b10, b11;
    {a00, a01, a10, a11, b00, b01, b10, b11} = '0;
    case (t)
      0: b01 = b[7:4];
      1: begin b00 = b[3:0]; b10 = b[11:8]; end
      2: begin b11 = b[15:12]; a00 = a[3:0]; end
      3: begin a01 = a[7:4]; a10 = a[11:8]; end
      4: a11 = a[15:12];
      default: ;
    endcase
    return {a00, a01, a10, a11, b00, b01, b10, b11};
  endfunction

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle J+1.
  task automatic start_job(input logic [15:0] a, input logic [15:0] b);
    bus.job_a     = a;
    bus.job_b     = b;
    bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic pulse_res_ready();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic set_stub(input int lat, input logic [8:0] c00, input logic [8:0] c01,
                          input logic [8:0] c10, input logic [8:0] c11);
    stub_lat = lat;
    stub_c00 = c00;
    stub_c01 = c01;
    stub_c10 = c10;
    stub_c11 = c11;
  endtask

  task automatic test_reset();
    #3;
    n_run++;
    if ({bus.job_ready, bus.busy, bus.res_valid, bus.res_err, bus.arr_in_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.job_ready, bus.busy, bus.res_valid, bus.res_err, bus.arr_in_valid});
    end
    n_run++;
    if (obs_ops !== 32'h0) begin
      n_fail++; $display("FAIL reset_ops: got %h want 0", obs_ops);
    end
    n_run++;
    if (bus.res_c !== 36'h0) begin
      n_fail++; $display("FAIL reset_res_c: got %h want 0", bus.res_c);
    end
    skip(2);
    rstn = 1'b1;
    skip(1);
    n_run++;
    if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: job_ready=%b busy=%b want 1 0", bus.job_ready, bus.busy);
    end
  endtask

  task automatic test_single_job();
    logic [31:0] exp_seq [5];
    exp_seq[0] = 32'h0000_0200;
    exp_seq[1] = 32'h0000_4060;
    exp_seq[2] = 32'h4000_0008;
    exp_seq[3] = 32'h03C0_0000;
    exp_seq[4] = 32'h0004_0000;
    set_stub(4, 9'd1, 9'd2, 9'd3, 9'd4);
    start_job(16'h4C34, 16'h8624);
    for (int t = 0; t < 5; t++) begin
      n_run++;
      if (obs_ops !== exp_seq[t] || bus.arr_in_valid !== (t >= 2)) begin
        n_fail++;
        $display("FAIL single_issue_t%0d: ops=%h in_valid=%b want %h %b",
                 t, obs_ops, bus.arr_in_valid, exp_seq[t], (t >= 2));
      end
      skip(1);
    end
    for (int w = 0; w < 4; w++) begin
      n_run++;
      if (obs_ops !== 32'h0 || bus.arr_in_valid !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_wait%0d: ops=%h in_valid=%b res_valid=%b want 0 1 0",
                 w, obs_ops, bus.arr_in_valid, bus.res_valid);
      end
      skip(1);
    end
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_c !== {9'd4, 9'd3, 9'd2, 9'd1} ||
        bus.res_err !== 1'b0 || bus.arr_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: valid=%b c=%h err=%b in_valid=%b want 1 %h 0 0",
               bus.res_valid, bus.res_c, bus.res_err, bus.arr_in_valid,
               {9'd4, 9'd3, 9'd2, 9'd1});
    end
    pulse_res_ready();
    n_run++;
    if (bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: job_ready=%b res_valid=%b want 1 0",
               bus.job_ready, bus.res_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp_c;
    exp_c = {9'd511, 9'd300, 9'd200, 9'd100};
    set_stub(4, 9'd100, 9'd200, 9'd300, 9'd511);
    start_job(16'h5321, 16'h1234);
    skip(9);
    // Array outputs move while held; the registered result must not.
    set_stub(4, 9'd7, 9'd7, 9'd7, 9'd7);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (bus.res_valid !== 1'b1 || bus.res_c !== exp_c || bus.job_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: valid=%b c=%h job_ready=%b want 1 %h 0",
                 i, bus.res_valid, bus.res_c, bus.job_ready, exp_c);
      end
      skip(1);
    end
    pulse_res_ready();
    n_run++;
    if (bus.res_valid !== 1'b0 || bus.job_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b job_ready=%b want 0 1",
               bus.res_valid, bus.job_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2;
    int n;
    a1 = 16'h1234; b1 = 16'h5678; a2 = 16'h9ABC; b2 = 16'hDEF1;
    set_stub(4, 9'd11, 9'd22, 9'd33, 9'd44);
    bus.job_a = a1; bus.job_b = b1; bus.job_valid = 1'b1;
    skip(1);
    bus.job_a = a2; bus.job_b = b2;
    n_run++;
    if (obs_ops !== exp_ops(a1, b1, 0)) begin
      n_fail++; $display("FAIL b2b_job1_t0: got %h want %h", obs_ops, exp_ops(a1, b1, 0));
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin skip(1); n++; end
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_c !== {9'd44, 9'd33, 9'd22, 9'd11}) begin
      n_fail++;
      $display("FAIL b2b_job1_result: valid=%b c=%h want 1 %h",
               bus.res_valid, bus.res_c, {9'd44, 9'd33, 9'd22, 9'd11});
    end
    pulse_res_ready();
    n_run++;
    if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || obs_ops !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_idle: job_ready=%b busy=%b ops=%h want 1 0 0",
               bus.job_ready, bus.busy, obs_ops);
    end
    skip(1);
    bus.job_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      n_run++;
      if (obs_ops !== exp_ops(a2, b2, t)) begin
        n_fail++;
        $display("FAIL b2b_job2_t%0d: got %h want %h", t, obs_ops, exp_ops(a2, b2, t));
      end
      skip(1);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin skip(1); n++; end
    n_run++;
    if (bus.res_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_job2_result: valid=%b want 1", bus.res_valid);
    end
    pulse_res_ready();
  endtask

  task automatic test_reset_mid_issue();
    set_stub(4, 9'd5, 9'd6, 9'd7, 9'd8);
    start_job(16'hFFFF, 16'hFFFF);
    skip(3);
    rstn = 1'b0;
    #1;
    n_run++;
    if (obs_ops !== 32'h0 || bus.arr_in_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.job_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drive: ops=%h in_valid=%b busy=%b job_ready=%b valid=%b want 0",
               obs_ops, bus.arr_in_valid, bus.busy, bus.job_ready, bus.res_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_run++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet%0d: valid=%b busy=%b want 0 0",
                 i, bus.res_valid, bus.busy);
      end
      skip(1);
    end
    set_stub(2, 9'd9, 9'd10, 9'd11, 9'd12);
    start_job(16'h2468, 16'h1357);
    n_run++;
    if (obs_ops !== exp_ops(16'h2468, 16'h1357, 0)) begin
      n_fail++;
      $display("FAIL midreset_next_t0: got %h want %h", obs_ops, exp_ops(16'h2468, 16'h1357, 0));
    end
    skip(7);
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_c !== {9'd12, 9'd11, 9'd10, 9'd9}) begin
      n_fail++;
      $display("FAIL midreset_next_result: valid=%b c=%h want 1 %h",
               bus.res_valid, bus.res_c, {9'd12, 9'd11, 9'd10, 9'd9});
    end
    pulse_res_ready();
  endtask

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    set_stub(1000, 9'd1, 9'd1, 9'd1, 9'd1);
    start_job(16'h1111, 16'h2222);
    skip(19);
    n_run++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: valid=%b want 0", bus.res_valid);
    end
    skip(1);
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_c !== 36'h0) begin
      n_fail++;
      $display("FAIL timeout_abort: valid=%b err=%b c=%h want 1 1 0",
               bus.res_valid, bus.res_err, bus.res_c);
    end
    pulse_res_ready();
  endtask

  task automatic test_timeout_edge();
    set_stub(15, 9'd21, 9'd22, 9'd23, 9'd24);
    start_job(16'h3333, 16'h4444);
    skip(19);
    n_run++;
    if (bus.res_valid !== 1'b0 || bus.arr_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge_pre: valid=%b out_valid=%b want 0 1",
               bus.res_valid, bus.arr_out_valid);
    end
    skip(1);
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b0 ||
        bus.res_c !== {9'd24, 9'd23, 9'd22, 9'd21}) begin
      n_fail++;
      $display("FAIL timeout_edge_result: valid=%b err=%b c=%h want 1 0 %h",
               bus.res_valid, bus.res_err, bus.res_c, {9'd24, 9'd23, 9'd22, 9'd21});
    end
    pulse_res_ready();
  endtask
`else
  task automatic test_long_wait();
    set_stub(30, 9'd31, 9'd32, 9'd33, 9'd34);
    start_job(16'h5555, 16'h6666);
    skip(34);
    n_run++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1 || bus.arr_in_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL long_wait_hold: valid=%b busy=%b in_valid=%b want 0 1 1",
               bus.res_valid, bus.busy, bus.arr_in_valid);
    end
    skip(1);
    n_run++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b0 ||
        bus.res_c !== {9'd34, 9'd33, 9'd32, 9'd31}) begin
      n_fail++;
      $display("FAIL long_wait_result: valid=%b err=%b c=%h want 1 0 %h",
               bus.res_valid, bus.res_err, bus.res_c, {9'd34, 9'd33, 9'd32, 9'd31});
    end
    pulse_res_ready();
  endtask
`endif

  initial begin
    n_run         = 0;
    n_fail        = 0;
    rstn          = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_a     = '0;
    bus.job_b     = '0;
    bus.res_ready = 1'b0;
    set_stub(4, 9'd0, 9'd0, 9'd0, 9'd0);
    test_reset();
    test_single_job();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_issue();
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`else
    test_long_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
